// File: rtl/jx2_fetch_align.sv
// Instruction-fetch aligner for the JX2 front end.
// Issues aligned 64-bit fetches, keeps up to eight halfwords buffered and
// hands one left-justified 16/32/48-bit instruction per handshake to decode.
// Build option: JX2_FALIGN_ZERO_TAIL_EN zeroes ifWord above the instruction.
module jx2_fetch_align #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fetchReqValid,
  output logic [ADDR_W-1:0] fetchReqAddr,
  input  logic              fetchReqReady,
  input  logic              fetchRespValid,
  input  logic [63:0]       fetchRespData,
  input  logic              redirValid,
  input  logic [ADDR_W-1:0] redirPc,
  output logic              ifValid,
  input  logic              ifReady,
  output logic [63:0]       ifWord,
  output logic [1:0]        ifLen,
  output logic [ADDR_W-1:0] ifPc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t            state_q;
  logic [127:0]      buf_q;
  logic [3:0]        occ_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] head_pc_q;
  logic [1:0]        skip_q;

  logic [1:0]        head_len;
  logic [1:0]        shift_len;
  logic              xfer;
  logic              take_resp;
  logic              owed_after;
  logic [127:0]      buf_s;
  logic [127:0]      buf_d;
  logic [127:0]      resp_ext;
  logic [63:0]       resp_hw;
  logic [3:0]        occ_s;
  logic [3:0]        occ_d;
  logic              unused_redir_bit0;

  assign unused_redir_bit0 = redirPc[0];

  // Instruction length from the top six bits of the head halfword.
  always_comb begin
    head_len = 2'd1;
    casez (buf_q[15:10])
      6'b11111?:                      head_len = 2'd3;
      6'b1110??, 6'b11110?, 6'b11011?: head_len = 2'd2;
      default:                        head_len = 2'd1;
    endcase
  end

  assign ifValid       = (occ_q != 4'd0) && (occ_q >= {2'b00, head_len}) && !redirValid;
  assign ifLen         = head_len;
  assign ifPc          = head_pc_q;
  assign xfer          = ifValid && ifReady;
  assign fetchReqValid = (state_q == S_REQ);
  assign fetchReqAddr  = fetch_pc_q;

`ifdef JX2_FALIGN_ZERO_TAIL_EN
  logic [63:0] tail_mask;

  // Keep only the halfwords that belong to the head instruction.
  always_comb begin
    tail_mask = 64'h0000_0000_0000_FFFF;
    case (head_len)
      2'd2:    tail_mask = 64'h0000_0000_FFFF_FFFF;
      2'd3:    tail_mask = 64'h0000_FFFF_FFFF_FFFF;
      default: tail_mask = 64'h0000_0000_0000_FFFF;
    endcase
  end

  assign ifWord = buf_q[63:0] & tail_mask;
`else
  // Unfilled slots are always zero, so the raw window is already well-formed.
  assign ifWord = buf_q[63:0];
`endif

  // Buffer next state: retire the head on a transfer, then append the
  // usable part of a response directly behind what remains.
  always_comb begin
    shift_len  = xfer ? head_len : 2'd0;
    buf_s      = buf_q >> {shift_len, 4'b0000};
    occ_s      = occ_q - {2'b00, shift_len};
    resp_hw    = fetchRespData >> {skip_q, 4'b0000};
    resp_ext   = {64'b0, resp_hw} << {occ_s, 4'b0000};
    take_resp  = (state_q == S_WAIT) && fetchRespValid;
    buf_d      = take_resp ? (buf_s | resp_ext) : buf_s;
    occ_d      = take_resp ? (occ_s + 4'd4 - {2'b00, skip_q}) : occ_s;
    // A response is still owed after this cycle if one was pending and did
    // not arrive, or if a new request is accepted right now.
    owed_after = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !fetchRespValid) ||
                 ((state_q == S_REQ) && fetchReqReady);
  end

  // Fetch FSM, buffer and PC registers; a redirect overrides everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      occ_q      <= 4'd0;
      fetch_pc_q <= {RESET_PC[ADDR_W-1:3], 3'b000};
      head_pc_q  <= {RESET_PC[ADDR_W-1:1], 1'b0};
      skip_q     <= RESET_PC[2:1];
    end else if (redirValid) begin
      state_q    <= owed_after ? S_DRAIN : S_REQ;
      buf_q      <= '0;
      occ_q      <= 4'd0;
      fetch_pc_q <= {redirPc[ADDR_W-1:3], 3'b000};
      head_pc_q  <= {redirPc[ADDR_W-1:1], 1'b0};
      skip_q     <= redirPc[2:1];
    end else begin
      buf_q <= buf_d;
      occ_q <= occ_d;
      if (xfer) begin
        head_pc_q <= head_pc_q + {{(ADDR_W-3){1'b0}}, head_len, 1'b0};
      end
      case (state_q)
        S_IDLE: begin
          if (occ_q <= 4'd4) state_q <= S_REQ;
        end
        S_REQ: begin
          if (fetchReqReady) begin
            state_q    <= S_WAIT;
            fetch_pc_q <= fetch_pc_q + ADDR_W'(8);
          end
        end
        S_WAIT: begin
          if (fetchRespValid) begin
            skip_q  <= 2'd0;
            state_q <= (occ_d <= 4'd4) ? S_REQ : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (fetchRespValid) state_q <= S_REQ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
